// File: rtl/pool2x2_stream.sv
// pool2x2_stream: streaming 2x2/stride-2 max/average pooling over a raster-order multi-channel feature map
module pool2x2_stream #(
  parameter int DATA_W = 22,
  parameter int IMG_W  = 30,
  parameter int IMG_H  = 30,
  parameter int CH     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     frame_done
);
  localparam int CW  = CH > 1 ? $clog2(CH) : 1;
  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H);
  localparam int LBD = (IMG_W / 2) * CH;
  localparam int LW  = LBD > 1 ? $clog2(LBD) : 1;
  localparam int PW  = 2 * (IMG_W / 2);
  localparam int PH  = 2 * (IMG_H / 2);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  logic [0:0]              r_state;
  logic                    r_mode;
  logic [CW-1:0]           r_ch;
  logic [XW-1:0]           r_x;
  logic [YW-1:0]           r_y;
  logic signed [DATA_W:0]  r_h  [2**CW];
  logic signed [DATA_W:0]  r_lb [2**LW];
  logic                    w_acc, w_ch_end, w_x_end, w_y_end, w_in_pool, w_emit, w_unused;
  logic [LW-1:0]           w_lbi;
  logic signed [DATA_W:0]  w_in, w_hv, w_lv, w_pair;
  logic signed [DATA_W+1:0] w_sum;
  logic signed [DATA_W-1:0] w_res;
  assign w_acc     = r_state == S_RUN && in_valid && !start;
  assign w_ch_end  = r_ch == CW'(CH - 1);
  assign w_x_end   = r_x == XW'(IMG_W - 1);
  assign w_y_end   = r_y == YW'(IMG_H - 1);
  // trailing odd column/row is consumed but never pooled
  assign w_in_pool = 32'(r_x) < PW && 32'(r_y) < PH;
  assign w_emit    = w_acc && w_in_pool && r_x[0] && r_y[0];
  assign w_lbi     = LW'(32'(r_x >> 1) * CH + 32'(r_ch));
  assign w_in      = {in_data[DATA_W-1], in_data};
  assign w_hv      = r_h[r_ch];
  assign w_lv      = r_lb[w_lbi];
  // avg carries exact partial sums; max carries the sign-extended winner
  assign w_pair    = r_mode ? w_hv + w_in : (w_hv > w_in ? w_hv : w_in);
  assign w_sum     = {w_lv[DATA_W], w_lv} + {w_pair[DATA_W], w_pair};
  assign w_res     = r_mode ? w_sum[DATA_W+1:2] : (w_lv > w_pair ? w_lv[DATA_W-1:0] : w_pair[DATA_W-1:0]);
  assign w_unused  = ^w_sum[1:0];
  assign busy      = r_state == S_RUN;
  always_ff @(posedge clk) begin
    if (w_acc && w_in_pool) begin
      if (!r_x[0]) r_h[r_ch] <= w_in;
      else if (!r_y[0]) r_lb[w_lbi] <= w_pair;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_ch       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= w_emit;
      out_last   <= w_acc && w_ch_end && 32'(r_x) == PW - 1 && 32'(r_y) == PH - 1;
      frame_done <= w_acc && w_ch_end && w_x_end && w_y_end;
      if (w_emit) out_data <= w_res;
      if (start) begin
        r_state <= S_RUN;
        r_mode  <= mode;
        r_ch    <= '0;
        r_x     <= '0;
        r_y     <= '0;
      end else if (w_acc) begin
        r_ch <= w_ch_end ? '0 : r_ch + 1'b1;
        if (w_ch_end) r_x <= w_x_end ? '0 : r_x + 1'b1;
        if (w_ch_end && w_x_end) r_y <= w_y_end ? '0 : r_y + 1'b1;
        if (w_ch_end && w_x_end && w_y_end) r_state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_pool2x2_stream.sv
// tb_pool2x2_stream: randomized and directed checks of pool2x2_stream against a frame-level pooling model
module tb_pool2x2_stream;
  localparam int DW = 22;
  localparam int PW [4] = '{30, 2, 4, 5};
  localparam int PH [4] = '{30, 2, 4, 5};
  localparam int PC [4] = '{1, 1, 2, 1};
  logic clk = 0, rst = 1, start = 0, mode = 0, in_valid = 0;
  logic signed [DW-1:0] in_data = '0;
  int sel = 0, n_vec = 0, n_err = 0, n_fd = 0;
  logic ov [4], ol [4], bz [4], fd [4];
  logic signed [DW-1:0] od [4];
  longint din [$], exp_q [$], got_d [$];
  bit got_l [$];
  always #5 clk = ~clk;
  pool2x2_stream #(.DATA_W(DW), .IMG_W(30), .IMG_H(30), .CH(1)) u0 (.clk(clk), .rst(rst),
    .start(start && sel == 0), .mode(mode), .in_valid(in_valid), .in_data(in_data), .out_valid(ov[0]),
    .out_data(od[0]), .out_last(ol[0]), .busy(bz[0]), .frame_done(fd[0]));
  pool2x2_stream #(.DATA_W(DW), .IMG_W(2), .IMG_H(2), .CH(1)) u1 (.clk(clk), .rst(rst),
    .start(start && sel == 1), .mode(mode), .in_valid(in_valid), .in_data(in_data), .out_valid(ov[1]),
    .out_data(od[1]), .out_last(ol[1]), .busy(bz[1]), .frame_done(fd[1]));
  pool2x2_stream #(.DATA_W(DW), .IMG_W(4), .IMG_H(4), .CH(2)) u2 (.clk(clk), .rst(rst),
    .start(start && sel == 2), .mode(mode), .in_valid(in_valid), .in_data(in_data), .out_valid(ov[2]),
    .out_data(od[2]), .out_last(ol[2]), .busy(bz[2]), .frame_done(fd[2]));
  pool2x2_stream #(.DATA_W(DW), .IMG_W(5), .IMG_H(5), .CH(1)) u3 (.clk(clk), .rst(rst),
    .start(start && sel == 3), .mode(mode), .in_valid(in_valid), .in_data(in_data), .out_valid(ov[3]),
    .out_data(od[3]), .out_last(ol[3]), .busy(bz[3]), .frame_done(fd[3]));
  always @(negedge clk) begin
    if (ov[sel]) begin
      got_d.push_back(longint'(od[sel]));
      got_l.push_back(ol[sel]);
    end
    if (fd[sel]) n_fd++;
  end
  task automatic check(string tag, longint got, longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic fill(int k, int kind);
    din.delete();
    for (int y = 0; y < PH[k]; y++)
      for (int x = 0; x < PW[k]; x++)
        for (int c = 0; c < PC[k]; c++) begin
          logic signed [DW-1:0] v;
          longint p;
          v = DW'($urandom);
          p = y * PW[k] + x;
          din.push_back(kind != 0 ? longint'(v) : (c != 0 ? -p : p));
        end
  endtask
  task automatic model(int k, bit m);
    int w, c;
    w = PW[k];
    c = PC[k];
    exp_q.delete();
    for (int yy = 0; yy < PH[k] / 2; yy++)
      for (int xx = 0; xx < w / 2; xx++)
        for (int ch = 0; ch < c; ch++) begin
          longint a, b, e, d, mx;
          a = din[((2 * yy) * w + 2 * xx) * c + ch];
          b = din[((2 * yy) * w + 2 * xx + 1) * c + ch];
          e = din[((2 * yy + 1) * w + 2 * xx) * c + ch];
          d = din[((2 * yy + 1) * w + 2 * xx + 1) * c + ch];
          mx = a;
          if (b > mx) mx = b;
          if (e > mx) mx = e;
          if (d > mx) mx = d;
          exp_q.push_back(m ? (a + b + e + d) >>> 2 : mx);
        end
  endtask
  task automatic beat(longint v, int gap);
    while ($urandom_range(99) < gap) begin
      @(posedge clk); #1;
    end
    in_valid = 1;
    in_data = DW'(v);
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic run(int k, bit m, int gap, int abort_n, string tag);
    sel = k;
    mode = m;
    if (abort_n > 0) begin
      @(posedge clk); #1; start = 1;
      @(posedge clk); #1; start = 0;
      for (int i = 0; i < abort_n; i++) beat(din[i], 0);
      @(negedge clk);
    end
    got_d.delete();
    got_l.delete();
    n_fd = 0;
    @(posedge clk); #1;
    start = 1;
    in_valid = abort_n > 0;
    in_data = DW'(din[abort_n]);
    @(posedge clk); #1;
    start = 0;
    in_valid = 0;
    @(negedge clk);
    check({tag, " busy after start"}, bz[k], 1);
    check({tag, " no out at start"}, ov[k], 0);
    for (int i = 0; i < din.size(); i++) beat(din[i], gap);
    @(negedge clk);
    check({tag, " frame_done"}, fd[k], 1);
    check({tag, " busy at end"}, bz[k], 0);
    @(negedge clk);
    check({tag, " frame_done pulse"}, fd[k], 0);
    repeat (3) @(negedge clk);
    check({tag, " frame_done count"}, n_fd, 1);
    model(k, m);
    check({tag, " out count"}, got_d.size(), exp_q.size());
    for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s data[%0d]", tag, i), got_d[i], exp_q[i]);
      check($sformatf("%s last[%0d]", tag, i), got_l[i], i == exp_q.size() - 1);
    end
  endtask
  task automatic expect_list(string tag, longint e [$]);
    for (int i = 0; i < e.size(); i++)
      check($sformatf("%s lit[%0d]", tag, i), i < got_d.size() ? got_d[i] : 64'hdead, e[i]);
  endtask
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its cycle budget");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset out_valid %0d", k), ov[k], 0);
      check($sformatf("reset out_data %0d", k), od[k], 0);
      check($sformatf("reset out_last %0d", k), ol[k], 0);
      check($sformatf("reset busy %0d", k), bz[k], 0);
      check($sformatf("reset frame_done %0d", k), fd[k], 0);
    end
    @(posedge clk); #1;
    rst = 0;
    fill(0, 0);
    for (int i = 0; i < 10; i++) beat(din[i], 0);
    repeat (2) @(negedge clk);
    check("idle ignores beats", got_d.size(), 0);
    check("idle busy", bz[0], 0);
    run(0, 0, 0, 0, "t1");
    check("t1 first", got_d.size() > 0 ? got_d[0] : 64'hdead, 31);
    check("t1 last", got_d.size() > 0 ? got_d[got_d.size() - 1] : 64'hdead, 899);
    din = '{-1, -2, -3, -4};
    run(1, 1, 0, 0, "t2 neg");
    expect_list("t2 neg", '{-3});
    din = '{1, 2, 3, 4};
    run(1, 1, 0, 0, "t2 pos");
    expect_list("t2 pos", '{2});
    fill(2, 0);
    run(2, 0, 0, 0, "t3");
    expect_list("t3", '{5, 0, 7, -2, 13, -8, 15, -10});
    fill(3, 0);
    run(3, 0, 0, 0, "t4");
    expect_list("t4", '{6, 8, 16, 18});
    fill(0, 0);
    run(0, 0, 0, 91, "t5");
    check("t5 first", got_d.size() > 0 ? got_d[0] : 64'hdead, 31);
    run(0, 0, 50, 0, "t6");
    sel = 0;
    @(posedge clk); #1; start = 1;
    @(posedge clk); #1; start = 0;
    for (int i = 0; i < 400; i++) beat(din[i], 0);
    rst = 1;
    in_valid = 1;
    in_data = DW'(din[400]);
    @(posedge clk); #1;
    rst = 0;
    in_valid = 0;
    @(negedge clk);
    check("rst out_valid", ov[0], 0);
    check("rst out_data", od[0], 0);
    check("rst out_last", ol[0], 0);
    check("rst busy", bz[0], 0);
    got_d.delete();
    got_l.delete();
    n_fd = 0;
    for (int i = 401; i < 600; i++) beat(din[i], 0);
    repeat (2) @(negedge clk);
    check("post-rst outputs", got_d.size(), 0);
    check("post-rst busy", bz[0], 0);
    check("post-rst frame_done", n_fd, 0);
    for (int k = 0; k < 4; k++)
      for (int m = 0; m < 2; m++) begin
        fill(k, 1);
        run(k, m[0], 30, 0, $sformatf("rnd k%0d m%0d", k, m));
      end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
